// File: rtl/proc_io_hub.sv
// Processor I/O hub: per-channel input and output FIFOs behind a single
// addressed processor port, with fill-threshold interrupt and sticky error flags.
module proc_io_hub #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4,
    parameter int ITRTHR = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [NUBITS-1:0]          io_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    input  logic                       req_in,
    input  logic [NUBITS-1:0]          io_out,
    input  logic [$clog2(NUIOOU)-1:0]  addr_out,
    input  logic                       out_en,
    output logic                       itr,
    input  logic [NUIOIN*NUBITS-1:0]   ch_din,
    input  logic [NUIOIN-1:0]          ch_din_vld,
    output logic [NUIOIN-1:0]          ch_din_rdy,
    output logic [NUIOOU*NUBITS-1:0]   ch_dout,
    output logic [NUIOOU-1:0]          ch_dout_vld,
    input  logic [NUIOOU-1:0]          ch_dout_rdy,
    output logic [NUIOIN-1:0]          err_ufl,
    output logic [NUIOOU-1:0]          err_ofl,
    input  logic                       err_clr
);

    localparam int PW  = $clog2(FDEPTH);
    localparam int CW  = PW + 1;
    localparam int AIW = $clog2(NUIOIN);
    localparam int AOW = $clog2(NUIOOU);
    localparam logic [CW-1:0] FULL = CW'(FDEPTH);
    localparam logic [CW-1:0] THR  = CW'(ITRTHR);

    logic [NUBITS-1:0] in_head [NUIOIN];
    logic [NUIOIN-1:0] lvl;
    logic [NUIOIN-1:0] lvl_d;

    // Input channels: filled by the peripheral, drained by processor reads.
    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        logic [NUBITS-1:0] mem [FDEPTH];
        logic [PW-1:0]     rp;
        logic [PW-1:0]     wp;
        logic [CW-1:0]     cnt;
        logic              sel;
        logic              push;
        logic              pop;
        logic              ufl;

        assign sel           = (addr_in == AIW'(k));
        assign ch_din_rdy[k] = (cnt != FULL);
        assign push          = ch_din_vld[k] && (cnt != FULL);
        assign pop           = req_in && sel && (cnt != '0);
        assign lvl[k]        = (cnt >= THR);
        assign in_head[k]    = (cnt != '0) ? mem[rp] : '0;
        assign err_ufl[k]    = ufl;

        always_ff @(posedge clk) begin
            if (!rst && push) begin
                mem[wp] <= ch_din[k*NUBITS +: NUBITS];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rp  <= '0;
                wp  <= '0;
                cnt <= '0;
                ufl <= 1'b0;
            end else begin
                if (push) wp <= wp + PW'(1);
                if (pop)  rp <= rp + PW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
                if (err_clr) begin
                    ufl <= 1'b0;
                end else if (req_in && sel && (cnt == '0)) begin
                    ufl <= 1'b1;
                end
            end
        end
    end

    // Out-of-range addresses match no channel and so read as zero.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (addr_in == AIW'(i)) io_in = in_head[i];
        end
    end

    // Output channels: filled by processor writes, drained by the peripheral.
    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        logic [NUBITS-1:0] mem [FDEPTH];
        logic [PW-1:0]     rp;
        logic [PW-1:0]     wp;
        logic [CW-1:0]     cnt;
        logic              sel;
        logic              push;
        logic              pop;
        logic              ofl;

        assign sel            = (addr_out == AOW'(j));
        assign push           = out_en && sel && (cnt != FULL);
        assign pop            = ch_dout_rdy[j] && (cnt != '0);
        assign ch_dout_vld[j] = (cnt != '0);
        assign ch_dout[j*NUBITS +: NUBITS] = (cnt != '0) ? mem[rp] : '0;
        assign err_ofl[j]     = ofl;

        always_ff @(posedge clk) begin
            if (!rst && push) begin
                mem[wp] <= io_out;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rp  <= '0;
                wp  <= '0;
                cnt <= '0;
                ofl <= 1'b0;
            end else begin
                if (push) wp <= wp + PW'(1);
                if (pop)  rp <= rp + PW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
                if (err_clr) begin
                    ofl <= 1'b0;
                end else if (out_en && sel && (cnt == FULL)) begin
                    ofl <= 1'b1;
                end
            end
        end
    end

    // Rising edge of any channel's level produces one merged interrupt pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_d <= '0;
            itr   <= 1'b0;
        end else begin
            lvl_d <= lvl;
            itr   <= |(lvl & ~lvl_d);
        end
    end

endmodule
